// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction
// memory, and holds each fetched instruction for decode until it is consumed or squashed.
module ifu #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            squash_q, squash_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [XLEN-1:0] target;

  // Fetches are always word-aligned, so the low two target bits are dropped.
  assign target = redirect_pc & ~XLEN'(3);

  always_comb begin
    // NOTE: every next-state signal gets a hold-value default first so no path infers a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    squash_d      = squash_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          if (redirect_valid) begin
            // Request already accepted for the old address; drop its response.
            fetch_pc_d = target;
            squash_d   = 1'b1;
          end
        end else if (redirect_valid) begin
          fetch_pc_d = target;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          state_d  = S_REQ;
          squash_d = 1'b0;
          if (redirect_valid) begin
            fetch_pc_d = target;
          end else if (!squash_q) begin
            state_d       = S_HOLD;
            instr_d       = imem_resp_data;
            pc_d          = fetch_pc_q;
            instr_valid_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + XLEN'(4);
          end
        end else if (redirect_valid) begin
          fetch_pc_d = target;
          squash_d   = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          state_d       = S_REQ;
          instr_valid_d = 1'b0;
          fetch_pc_d    = target;
        end else if (instr_ready) begin
          state_d       = S_REQ;
          instr_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      squash_q      <= 1'b0;
      instr_q       <= 32'h0;
      pc_q          <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      squash_q      <= squash_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a small in-bench memory responder (data = addr ^ 0x13)
// drives the fetch port; each task checks hand-computed cycle-by-cycle expectations.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        a_req_valid, b_req_valid, a_ivalid, b_ivalid;
  logic [31:0] a_addr, b_addr, a_instr, b_instr, a_pc, b_pc;

  // use_b selects the instance built with RESET_PC = 0xFFFFFFFC.
  logic        use_b;
  logic        req_valid, ivalid;
  logic [31:0] addr, instr_o, pc_o;

  assign req_valid = use_b ? b_req_valid : a_req_valid;
  assign addr      = use_b ? b_addr      : a_addr;
  assign ivalid    = use_b ? b_ivalid    : a_ivalid;
  assign instr_o   = use_b ? b_instr     : a_instr;
  assign pc_o      = use_b ? b_pc        : a_pc;

  ifu u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(a_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(a_ivalid), .instr_ready(instr_ready), .instr(a_instr), .pc(a_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  ifu #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(b_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(b_ivalid), .instr_ready(instr_ready), .instr(b_instr), .pc(b_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle;

  // Memory responder state: one outstanding request, response after mem_lat cycles.
  logic        mem_pending;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_addr;

  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    logic        was_rst;
    logic        resp_now;
    hs       = req_valid && imem_req_ready;
    hs_addr  = addr;
    was_rst  = rst;
    resp_now = imem_resp_valid;
    @(posedge clk);
    #1;
    cycle++;
    if (was_rst || resp_now) mem_pending = 1'b0;
    if (!was_rst && hs) begin
      mem_pending = 1'b1;
      mem_cnt     = mem_lat;
      mem_addr    = hs_addr;
    end else if (mem_pending) begin
      mem_cnt--;
    end
    imem_resp_valid = mem_pending && (mem_cnt == 1);
    imem_resp_data  = imem_resp_valid ? (mem_addr ^ 32'h13) : 32'h0;
    #1;
  endtask

  task automatic do_reset(input logic sel);
    use_b           = sel;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    mem_pending     = 1'b0;
    mem_cnt         = 0;
    mem_lat         = 1;
    repeat (2) tick();
    rst   = 1'b0;
    #1;
    cycle = 0;
  endtask

  task automatic test_reset();
    use_b = 1'b0;
    rst   = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    mem_pending = 1'b0;
    mem_lat = 1;
    repeat (3) tick();
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %0b want 0", req_valid); end
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid: got %0b want 0", ivalid); end
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", pc_o); end
    vectors++; if (instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", instr_o); end
    rst = 1'b0;
    #1;
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL reset_c0_req_valid: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h8000_0000) begin miscompares++; $display("FAIL reset_c0_addr: got %h want 80000000", addr); end
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL reset_c0_instr_valid: got %0b want 0", ivalid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_pc = 32'h8000_0000 + 32'(4 * (c / 3));
      vectors++;
      if (ivalid !== ((c % 3) == 2)) begin
        miscompares++; $display("FAIL seq_instr_valid c%0d: got %0b want %0b", c, ivalid, (c % 3) == 2);
      end
      if ((c % 3) == 2) begin
        vectors++; if (pc_o !== exp_pc) begin miscompares++; $display("FAIL seq_pc c%0d: got %h want %h", c, pc_o, exp_pc); end
        vectors++; if (instr_o !== (exp_pc ^ 32'h13)) begin miscompares++; $display("FAIL seq_instr c%0d: got %h want %h", c, instr_o, exp_pc ^ 32'h13); end
      end
      vectors++;
      if (req_valid !== ((c % 3) == 0)) begin
        miscompares++; $display("FAIL seq_req_valid c%0d: got %0b want %0b", c, req_valid, (c % 3) == 0);
      end
      if ((c % 3) == 0) begin
        vectors++; if (addr !== exp_pc) begin miscompares++; $display("FAIL seq_addr c%0d: got %h want %h", c, addr, exp_pc); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL bp_instr_valid %0d: got %0b want 1", i, ivalid); end
      vectors++; if (pc_o !== 32'h8000_0000) begin miscompares++; $display("FAIL bp_pc %0d: got %h want 80000000", i, pc_o); end
      vectors++; if (instr_o !== 32'h8000_0013) begin miscompares++; $display("FAIL bp_instr %0d: got %h want 80000013", i, instr_o); end
      vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid %0d: got %0b want 0", i, req_valid); end
      tick();
    end
    instr_ready = 1'b1;
    vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL bp_release_valid: got %0b want 1", ivalid); end
    tick();
    instr_ready = 1'b0;
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL bp_after_valid: got %0b want 0", ivalid); end
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL bp_next_req_valid: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h8000_0004) begin miscompares++; $display("FAIL bp_next_addr: got %h want 80000004", addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_lat        = 4;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0101;
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    for (int c = 2; c < 5; c++) begin
      vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL rw_instr_valid c%0d: got %0b want 0", c, ivalid); end
      vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL rw_req_valid c%0d: got %0b want 0", c, req_valid); end
      tick();
    end
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL rw_discard_valid: got %0b want 0", ivalid); end
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL rw_req_valid: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h8000_0100) begin miscompares++; $display("FAIL rw_addr: got %h want 80000100", addr); end
    tick();
    tick();
    vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL rw_out_valid: got %0b want 1", ivalid); end
    vectors++; if (pc_o !== 32'h8000_0100) begin miscompares++; $display("FAIL rw_out_pc: got %h want 80000100", pc_o); end
    vectors++; if (instr_o !== 32'h8000_0113) begin miscompares++; $display("FAIL rw_out_instr: got %h want 80000113", instr_o); end
  endtask

  task automatic test_redirect_resp_hold();
    do_reset(1'b0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_100A;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL rr_drop_valid: got %0b want 0", ivalid); end
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL rr_req_valid: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h0000_1008) begin miscompares++; $display("FAIL rr_addr: got %h want 00001008", addr); end
    tick();
    tick();
    vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL rr_out_valid: got %0b want 1", ivalid); end
    vectors++; if (pc_o !== 32'h0000_1008) begin miscompares++; $display("FAIL rr_out_pc: got %h want 00001008", pc_o); end
    vectors++; if (instr_o !== 32'h0000_101B) begin miscompares++; $display("FAIL rr_out_instr: got %h want 0000101b", instr_o); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL rh_clear_valid: got %0b want 0", ivalid); end
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL rh_req_valid: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h0000_2000) begin miscompares++; $display("FAIL rh_addr: got %h want 00002000", addr); end
    tick();
    tick();
    vectors++; if (pc_o !== 32'h0000_2000) begin miscompares++; $display("FAIL rh_out_pc: got %h want 00002000", pc_o); end
    vectors++; if (instr_o !== 32'h0000_2013) begin miscompares++; $display("FAIL rh_out_instr: got %h want 00002013", instr_o); end
  endtask

  task automatic test_wrap_stall();
    do_reset(1'b1);
    instr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        #1;
      end
      vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL wr_stall_req_valid c%0d: got %0b want 1", c, req_valid); end
      vectors++; if (addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_stall_addr c%0d: got %h want fffffffc", c, addr); end
      vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL wr_stall_valid c%0d: got %0b want 0", c, ivalid); end
      tick();
    end
    imem_req_ready = 1'b1;
    vectors++; if (addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_accept_addr: got %h want fffffffc", addr); end
    tick();
    tick();
    vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL wr_out_valid: got %0b want 1", ivalid); end
    vectors++; if (pc_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_out_pc: got %h want fffffffc", pc_o); end
    vectors++; if (instr_o !== 32'hFFFF_FFEF) begin miscompares++; $display("FAIL wr_out_instr: got %h want ffffffef", instr_o); end
    tick();
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL wr_next_req_valid: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h0000_0000) begin miscompares++; $display("FAIL wr_next_addr: got %h want 00000000", addr); end
    use_b = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset(1'b0);
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    mem_lat        = 3;
    tick();
    rst = 1'b1;
    #1;
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_req_comb: got %0b want 0", req_valid); end
    tick();
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_valid: got %0b want 0", ivalid); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_req_valid: got %0b want 0", req_valid); end
    rst     = 1'b0;
    mem_lat = 1;
    #1;
    cycle = 0;
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL rst_wait_restart_req: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_wait_restart_addr: got %h want 80000000", addr); end
    tick();
    tick();
    vectors++; if (ivalid !== 1'b1) begin miscompares++; $display("FAIL rst_hold_setup_valid: got %0b want 1", ivalid); end
    rst = 1'b1;
    tick();
    vectors++; if (ivalid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid: got %0b want 0", ivalid); end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_req_valid: got %0b want 0", req_valid); end
    vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_hold_pc: got %h want 00000000", pc_o); end
    rst = 1'b0;
    #1;
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL rst_hold_restart_req: got %0b want 1", req_valid); end
    vectors++; if (addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_hold_restart_addr: got %h want 80000000", addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp_hold();
    test_wrap_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core: owns the program counter, fetches 32-bit instructions from instruction memory with a request/response handshake, and presents one instruction plus its PC to the decode stage (`idu`) under a valid/ready handshake. It sits directly upstream of `idu`, whose `instr` input is this block's `instr` output. Control-flow redirects from execute replace the sequential PC and squash any in-flight or held fetch.

## Interface
- `XLEN`, 32: PC/address width.
- `RESET_PC`, 32'h8000_0000: PC after reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  XLEN  fetch address (always word-aligned).
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_data`  in  32  fetched instruction word.
- `instr_valid`  out  1  `instr`/`pc` valid to decode.
- `instr_ready`  in  1  decode consumes instruction.
- `instr`  out  32  instruction to `idu`.
- `pc`  out  XLEN  address of `instr`.
- `redirect_valid`  in  1  control-flow redirect.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] ignored.

## Operation
- Registers: `fetch_pc` (XLEN), `state` (REQ/WAIT/HOLD), `squash` (1), `instr` (32), `pc` (XLEN), `instr_valid` (1).
- Reset: `state`=REQ, `fetch_pc`=RESET_PC, `squash`=0, `instr`=0, `pc`=0, `instr_valid`=0. `imem_req_valid` is 0 in any cycle with `rst`=1.
- `imem_req_valid` = (`state`==REQ) && !`rst`; `imem_addr` = `fetch_pc`.
- Redirect target is always written as {`redirect_pc`[XLEN-1:2], 2'b00}.
- REQ:
  - req handshake, no redirect -> WAIT.
  - req handshake with redirect -> `fetch_pc`=target, `squash`=1, -> WAIT.
  - no handshake, redirect -> `fetch_pc`=target, stay REQ. `imem_addr` may change while `imem_req_valid` is high and unaccepted.
- WAIT (exactly one request outstanding):
  - resp, `squash`=0, no redirect -> `instr`=`imem_resp_data`, `pc`=`fetch_pc`, `instr_valid`=1, `fetch_pc`=`fetch_pc`+4, -> HOLD.
  - resp, `squash`=1 -> discard data, `squash`=0, -> REQ.
  - resp with redirect -> discard data, `fetch_pc`=target, `squash`=0, -> REQ.
  - no resp, redirect -> `fetch_pc`=target, `squash`=1, stay WAIT.
- HOLD (`instr_valid`=1; `instr`/`pc` stable):
  - `instr_ready`, no redirect -> `instr_valid`=0, -> REQ.
  - redirect, with or without `instr_ready` -> `instr_valid`=0, `fetch_pc`=target, -> REQ. Redirect overrides the sequential PC.
- `imem_resp_valid` in REQ or HOLD is ignored.
- PC increment wraps modulo 2^XLEN: 0xFFFF_FFFC+4 = 0.
- `rst` in any state overrides everything. An outstanding request is abandoned, and memory must not return a response for it after reset.

## Timing
- Cycle 0 = first cycle with `rst`=0: `imem_req_valid`=1, `imem_addr`=RESET_PC.
- Minimum latency: request handshake at cycle N, response at N+1, `instr_valid`=1 at N+2.
- Peak throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Memory latency is unbounded; the block waits in WAIT indefinitely.
- `instr_valid`, `instr`, and `pc` are registered outputs, with no combinational path from any input.
- `imem_req_valid` depends only on `state` and `rst`.
- Once `instr_valid`=1, `instr` and `pc` hold until a handshake or redirect occurs.
- A redirect takes effect on the next edge. The next request is to the target address, and no instruction from the old path is presented after a redirect cycle.

## Test plan
- Reset, memory ready always, 1-cycle latency, data = addr^0x13 -> requests to 0x80000000, 0x80000004, 0x80000008. `instr_valid` rises at cycles 2, 5, 8 with matching `pc`/`instr`.
- Decode back-pressure: `instr_ready`=0 for 4 cycles in HOLD -> `instr`/`pc` stable, no new request issued, and the next request is only to pc+4 after `instr_ready`=1.
- Redirect to 0x80000101 in WAIT, response 3 cycles later -> response discarded, next request to 0x80000100, and the first valid output has `pc`=0x80000100.
- Redirect coincident with a response, and redirect in HOLD with `instr_ready`=1 -> data dropped or `instr_valid` cleared next cycle, next request to the target, never to old pc+4.
- `imem_req_ready` low for 5 cycles, plus `RESET_PC`=0xFFFFFFFC -> request held at 0xFFFFFFFC, then the next fetch goes to 0x00000000 (wrap). A stray `imem_resp_valid` in REQ is ignored.
- `rst` asserted in WAIT and in HOLD -> next cycle `instr_valid`=0, `imem_req_valid`=0. After release, the fetch restarts at `RESET_PC`.
